// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier for the RV32M unit (MUL/MULH/MULHSU/MULHU).
// Two multiplier bits are retired per CALC cycle: W/2+1 iterations, then a
// one-cycle DONE state that presents the registered result with o_valid.
// Optional feature macro: ZERO_SKIP_EN -- a zero operand at accept bypasses
// CALC and goes straight to DONE with a zero product.
module booth_r4_multiplier #(
  parameter int DATA_WIDTH = 32  // must be even and >= 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [1:0]                i_op,
  input  logic [DATA_WIDTH-1:0]     i_A,
  input  logic [DATA_WIDTH-1:0]     i_B,
  input  logic                      i_flush,
  output logic                      o_valid,
  output logic [DATA_WIDTH-1:0]     o_Result,
  output logic [2*DATA_WIDTH-1:0]   o_Product
);

  localparam int W    = DATA_WIDTH;
  localparam int AW   = 2*W + 2;        // accumulator / multiplicand width
  localparam int BW   = W + 3;          // multiplier: W+2 extended bits plus appended 0
  localparam int ITER = W/2 + 1;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [AW-1:0]   mcand_q, mcand_d;
  logic [BW-1:0]   mplier_q, mplier_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            o_valid_q, o_valid_d;
  logic [W-1:0]    o_result_q, o_result_d;
  logic [2*W-1:0]  o_product_q, o_product_d;

  logic [AW-1:0]   pp;
  logic [AW-1:0]   acc_sum;
  logic            a_sgn, b_sgn;

  // A is signed for everything except MULHU; B is signed only for MUL/MULH.
  assign a_sgn = (i_op != OP_MULHU) & i_A[W-1];
  assign b_sgn = ~i_op[1] & i_B[W-1];

  // Booth recode of the low multiplier triplet {b2i+1, b2i, b2i-1}.
  always_comb begin
    pp = '0;
    unique case (mplier_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
  end

  // Accumulator wraps mod 2^(2W+2); only the low 2W bits are ever reported.
  assign acc_sum = acc_q + pp;

  // Next-state and datapath control for IDLE/CALC/DONE.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    o_valid_d   = 1'b0;
    o_result_d  = o_result_q;
    o_product_d = o_product_q;

    unique case (state_q)
      IDLE: begin
        // Flush outranks a simultaneous request.
        if (i_valid && !i_flush) begin
          op_d     = i_op;
          mcand_d  = {{(W+2){a_sgn}}, i_A};
          mplier_d = {{2{b_sgn}}, i_B, 1'b0};
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
`ifdef ZERO_SKIP_EN
          if (i_A == '0 || i_B == '0) begin
            state_d     = DONE;
            o_valid_d   = 1'b1;
            o_result_d  = '0;
            o_product_d = '0;
          end
`endif
        end
      end
      CALC: begin
        if (i_flush) begin
          // Abandon the operation; result registers keep the previous op's values.
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 2;
          mplier_d = {{2{mplier_q[BW-1]}}, mplier_q[BW-1:2]};
          if (cnt_q == CW'(ITER - 1)) begin
            state_d     = DONE;
            cnt_d       = '0;
            o_valid_d   = 1'b1;
            o_product_d = acc_sum[2*W-1:0];
            o_result_d  = (op_q == OP_MUL) ? acc_sum[W-1:0] : acc_sum[2*W-1:W];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      // The valid pulse is already on the wire during DONE; a flush here just
      // lands in IDLE like the normal path does.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All state and registered outputs; async active-low reset clears everything.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      o_valid_q   <= 1'b0;
      o_result_q  <= '0;
      o_product_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      o_valid_q   <= o_valid_d;
      o_result_q  <= o_result_d;
      o_product_q <= o_product_d;
    end
  end

  assign o_ready   = (state_q == IDLE);
  assign o_valid   = o_valid_q;
  assign o_Result  = o_result_q;
  assign o_Product = o_product_q;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Self-checking bench for booth_r4_multiplier at W=32: directed RV32M vectors,
// random operands against a plain-arithmetic reference, flush, reset and
// back-to-back throughput. Define ZERO_SKIP_EN here too when building that variant.
module tb_booth_r4_multiplier;

  localparam int W    = 32;
  localparam int ITER = W/2 + 1;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          i_valid;
  logic          o_ready;
  logic [1:0]    i_op;
  logic [W-1:0]  i_A, i_B;
  logic          i_flush;
  logic          o_valid;
  logic [W-1:0]  o_Result;
  logic [2*W-1:0] o_Product;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  booth_r4_multiplier #(.DATA_WIDTH(W)) dut (
    .clk(clk), .n_rst(n_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_A(i_A), .i_B(i_B), .i_flush(i_flush),
    .o_valid(o_valid), .o_Result(o_Result), .o_Product(o_Product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: extend each operand to 64 bits by its signedness, multiply mod 2^64.
  function automatic logic [63:0] ref_prod(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = (op != 2'b11 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    eb = (op[1] == 1'b0 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [63:0] p);
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Edges between the accept edge and the first o_valid sample.
  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef ZERO_SKIP_EN
    if (a == 0 || b == 0) return 0;
`endif
    return ITER;
  endfunction

  // Stimulus only: present a request (called #1 after an edge) and return
  // #1 after the edge that accepts it; operands are scrambled afterwards.
  task automatic do_accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int w;
    i_op = op; i_A = a; i_B = b; i_valid = 1'b1;
    w = 0;
    while (!o_ready && w < 50) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    i_valid = 1'b0; i_op = 2'($urandom); i_A = $urandom; i_B = $urandom;
  endtask

  // Waits for o_valid; lat = -1 if it never comes within the bound.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!o_valid) lat = -1;
  endtask

  task automatic test_reset;
    n_rst = 1'b0; i_valid = 0; i_flush = 0; i_op = 0; i_A = 0; i_B = 0;
    #12;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", o_ready); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    total++; if (o_Result !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", o_Result); end
    total++; if (o_Product !== '0) begin bad++; $display("FAIL reset_product got=%h want=0", o_Product); end
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [1:0]  ops [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] as  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [63:0] ep  [4] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000,
                             64'hFFFF_FFFF_0000_0001, 64'hFFFF_FFFE_0000_0001};
    logic [31:0] er  [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    int lat;
    for (int k = 0; k < 4; k++) begin
      do_accept(ops[k], as[k], bs[k]);
      wait_valid(lat);
      total++; if (lat != ITER) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", k, lat, ITER); end
      total++; if (o_Result !== er[k]) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", k, o_Result, er[k]); end
      total++; if (o_Product !== ep[k]) begin bad++; $display("FAIL dir%0d_product got=%h want=%h", k, o_Product, ep[k]); end
      @(posedge clk); #1;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_pulse_width got=%b want=0", k, o_valid); end
      total++; if (o_Result !== er[k]) begin bad++; $display("FAIL dir%0d_hold got=%h want=%h", k, o_Result, er[k]); end
    end
  endtask

  task automatic test_random;
    int lat;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [63:0] p;
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom);
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h7FFF_FFFF;
        default: ;
      endcase
      p = ref_prod(op, a, b);
      do_accept(op, a, b);
      wait_valid(lat);
      total++; if (lat != exp_lat(a, b)) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", k, lat, exp_lat(a, b)); end
      total++; if (o_Product !== p) begin bad++; $display("FAIL rnd%0d_product op=%0d a=%h b=%h got=%h want=%h", k, op, a, b, o_Product, p); end
      total++; if (o_Result !== ref_res(op, p)) begin bad++; $display("FAIL rnd%0d_result got=%h want=%h", k, o_Result, ref_res(op, p)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush;
    logic [31:0] old_r;
    logic [63:0] old_p;
    int seen, lat;
    old_r = o_Result; old_p = o_Product;
    do_accept(2'b00, 32'd3, 32'd5);
    repeat (4) begin @(posedge clk); #1; end
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", o_ready); end
    seen = 0;
    repeat (25) begin if (o_valid) seen++; @(posedge clk); #1; end
    total++; if (seen != 0) begin bad++; $display("FAIL flush_no_valid got=%0d pulses want=0", seen); end
    total++; if (o_Result !== old_r || o_Product !== old_p) begin
      bad++; $display("FAIL flush_outputs_held got=%h/%h want=%h/%h", o_Result, o_Product, old_r, old_p); end
    do_accept(2'b00, 32'd6, 32'd7);
    wait_valid(lat);
    total++; if (lat != ITER) begin bad++; $display("FAIL flush_next_latency got=%0d want=%0d", lat, ITER); end
    total++; if (o_Result !== 32'd42) begin bad++; $display("FAIL flush_next_result got=%h want=2a", o_Result); end
    @(posedge clk); #1;
    // Flush together with a request in IDLE: nothing is accepted.
    i_valid = 1'b1; i_flush = 1'b1; i_op = 2'b00; i_A = 32'd9; i_B = 32'd9;
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL flush_idle_ready got=%b want=1", o_ready); end
    seen = 0;
    repeat (22) begin if (o_valid) seen++; @(posedge clk); #1; end
    total++; if (seen != 0) begin bad++; $display("FAIL flush_idle_no_valid got=%0d want=0", seen); end
  endtask

  task automatic test_ignore_busy;
    int lat, rdy_bad;
    do_accept(2'b00, 32'd11, 32'd13);
    rdy_bad = 0; lat = 0;
    i_valid = 1'b1; i_A = 32'd99; i_B = 32'd99;
    repeat (5) begin if (o_ready !== 1'b0) rdy_bad++; @(posedge clk); #1; lat++; end
    i_valid = 1'b0;
    total++; if (rdy_bad != 0) begin bad++; $display("FAIL busy_ready got=%0d high cycles want=0", rdy_bad); end
    while (!o_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (lat != ITER) begin bad++; $display("FAIL busy_latency got=%0d want=%0d", lat, ITER); end
    total++; if (o_Result !== 32'd143) begin bad++; $display("FAIL busy_result got=%h want=8f", o_Result); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int seen;
    do_accept(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (5) begin @(posedge clk); #1; end
    n_rst = 1'b0; #1;
    total++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_ctrl got valid=%b ready=%b want 0/1", o_valid, o_ready); end
    total++; if (o_Result !== '0 || o_Product !== '0) begin
      bad++; $display("FAIL rstmid_outputs got=%h/%h want=0", o_Result, o_Product); end
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    repeat (22) begin if (o_valid) seen++; @(posedge clk); #1; end
    total++; if (seen != 0) begin bad++; $display("FAIL rstmid_no_valid got=%0d want=0", seen); end
  endtask

  task automatic test_zero;
    int lat;
    do_accept(2'b00, 32'd0, 32'h1234);
    wait_valid(lat);
    total++; if (lat != exp_lat(32'd0, 32'h1234)) begin
      bad++; $display("FAIL zero_latency got=%0d want=%0d", lat, exp_lat(32'd0, 32'h1234)); end
    total++; if (o_Result !== '0 || o_Product !== '0) begin
      bad++; $display("FAIL zero_result got=%h/%h want=0", o_Result, o_Product); end
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL zero_pulse_width got=%b want=0", o_valid); end
  endtask

  task automatic test_back_to_back;
    int lat, last, gap;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [63:0] p;
    last = -1;
    for (int k = 0; k < 5; k++) begin
      op = 2'($urandom); a = $urandom | 32'd1; b = $urandom | 32'd2;
      p = ref_prod(op, a, b);
      do_accept(op, a, b);
      wait_valid(lat);
      total++; if (o_Product !== p) begin bad++; $display("FAIL b2b%0d_product got=%h want=%h", k, o_Product, p); end
      if (last >= 0) begin
        gap = cyc - last;
        total++; if (gap != ITER + 2) begin bad++; $display("FAIL b2b%0d_spacing got=%0d want=%0d", k, gap, ITER + 2); end
      end
      last = cyc;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_flush;
    test_ignore_busy;
    test_reset_mid;
    test_zero;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
